// File: rtl/bus_memory_model.sv
// Memory responder for the top8227 CPU bus: programmable wait states on ready, back-door load port.
// Optional write-protected ROM region above ROM_BASE when MEM_ROM_PROTECT_EN is defined.
module bus_memory_model #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          READ_WAIT  = 0,
  parameter int          WRITE_WAIT = 0,
  parameter logic [15:0] ROM_BASE   = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  AddressBusHigh,
  input  logic [7:0]  AddressBusLow,
  input  logic        readNotWrite,
  input  logic [7:0]  dataBusOutput,
  input  logic        dataBusEnable,
  output logic [7:0]  dataBusInput,
  output logic        ready,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data
`ifdef MEM_ROM_PROTECT_EN
  ,
  output logic        write_violation
`endif
);

  // state  | meaning
  // S_IDLE | no stall pending; ready high unless a new access with wait states arrives
  // S_WAIT | stalling the CPU; r_cnt holds remaining low-ready cycles
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [15:0]           r_last_addr;
  logic                  r_last_rnw;
  logic                  r_valid;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [15:0]           w_addr_full;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_load_addr;
  logic [3:0]            w_wait;
  logic                  w_new_access;
  logic                  w_ready;
  logic                  w_cpu_wr;
  logic                  w_commit;

  assign w_addr_full  = {AddressBusHigh, AddressBusLow};
  assign w_addr       = w_addr_full[ADDR_WIDTH-1:0];
  assign w_load_addr  = load_addr[ADDR_WIDTH-1:0];
  assign w_wait       = readNotWrite ? 4'(READ_WAIT) : 4'(WRITE_WAIT);
  assign w_new_access = !r_valid || (w_addr_full != r_last_addr) || (readNotWrite != r_last_rnw);

  always_ff @(posedge clk) begin
    if (rst || load_en) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_valid     <= 1'b0;
      r_last_addr <= 16'h0000;
      r_last_rnw  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_new_access) begin
        r_valid     <= 1'b1;
        r_last_addr <= w_addr_full;
        r_last_rnw  <= readNotWrite;
      end
    end
  end

  // A changed address mid-stall restarts the count exactly as from idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_new_access) begin
      if (w_wait == 4'd0) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt   = w_wait - 4'd1;
        w_state_nxt = (w_wait == 4'd1) ? S_IDLE : S_WAIT;
      end
    end else if (r_state == S_WAIT) begin
      if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
      else               w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_ready = 1'b1;
    if (rst || load_en)             w_ready = 1'b0;
    else if (w_new_access)          w_ready = (w_wait == 4'd0);
    else if (r_state == S_WAIT)     w_ready = (r_cnt == 4'd0);
  end

  assign ready    = w_ready;
  assign w_cpu_wr = !readNotWrite && dataBusEnable && w_ready;

`ifdef MEM_ROM_PROTECT_EN
  logic w_rom_hit;
  logic r_write_violation;

  assign w_rom_hit       = (w_addr_full >= ROM_BASE);
  assign w_commit        = w_cpu_wr && !w_rom_hit;
  assign write_violation = r_write_violation;

  always_ff @(posedge clk) begin
    if (rst)                         r_write_violation <= 1'b0;
    else if (w_cpu_wr && w_rom_hit)  r_write_violation <= 1'b1;
  end
`else
  assign w_commit = w_cpu_wr;
`endif

  // Back-door load wins; ready is low during a load so no CPU write can collide.
  always_ff @(posedge clk) begin
    if (load_en)       r_mem[w_load_addr] <= load_data;
    else if (w_commit) r_mem[w_addr]      <= dataBusOutput;
  end

  assign dataBusInput = rst ? 8'h00 : r_mem[w_addr];

endmodule

// File: tb/tb_bus_memory_model.sv
// Scoreboard bench for bus_memory_model: two instances share the CPU bus with different
// width/wait settings; ROM protection checks follow MEM_ROM_PROTECT_EN.
module tb_bus_memory_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr_hi, addr_lo;
  logic        rnw;
  logic [7:0]  wdata;
  logic        data_en;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic [7:0]  d_a, d_b;
  logic        rdy_a, rdy_b;
`ifdef MEM_ROM_PROTECT_EN
  logic        wv_a, wv_b;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string      tag;
    logic [7:0] data;
    int         stalls;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  bus_memory_model #(.ADDR_WIDTH(16), .READ_WAIT(0), .WRITE_WAIT(3)) dut_a (
    .clk(clk), .rst(rst), .AddressBusHigh(addr_hi), .AddressBusLow(addr_lo),
    .readNotWrite(rnw), .dataBusOutput(wdata), .dataBusEnable(data_en),
    .dataBusInput(d_a), .ready(rdy_a), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
`ifdef MEM_ROM_PROTECT_EN
    , .write_violation(wv_a)
`endif
  );

  bus_memory_model #(.ADDR_WIDTH(12), .READ_WAIT(3), .WRITE_WAIT(2)) dut_b (
    .clk(clk), .rst(rst), .AddressBusHigh(addr_hi), .AddressBusLow(addr_lo),
    .readNotWrite(rnw), .dataBusOutput(wdata), .dataBusEnable(data_en),
    .dataBusInput(d_b), .ready(rdy_b), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
`ifdef MEM_ROM_PROTECT_EN
    , .write_violation(wv_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_load(input logic [15:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Expected data is the array content before the access (also what a write shows while stalled).
  task automatic cpu_access(input bit sel, input logic [15:0] a, input logic is_rd,
                            input logic [7:0] wd, input logic [7:0] exp_data,
                            input int exp_stalls, input string tag);
    exp_t e;
    int   stalls = 0;
    bit   done = 0;
    e.tag = tag; e.data = exp_data; e.stalls = exp_stalls;
    sb_q.push_back(e);
    {addr_hi, addr_lo} = a; rnw = is_rd; wdata = wd; data_en = !is_rd;
    for (int c = 0; c < 24 && !done; c++) begin
      @(negedge clk);
      if ((sel ? rdy_b : rdy_a) == 1'b1) begin
        e = sb_q.pop_front();
        chk({e.tag, "_stalls"}, stalls, e.stalls);
        chk({e.tag, "_data"}, sel ? d_b : d_a, e.data);
        done = 1;
      end else begin
        stalls++;
        chk({tag, "_hold"}, sel ? d_b : d_a, exp_data);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      e = sb_q.pop_front();
      chk({e.tag, "_timeout"}, 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; addr_hi = 8'hFF; addr_lo = 8'hFC; rnw = 1'b1; wdata = 8'h00;
    data_en = 1'b0; load_en = 1'b0; load_addr = 16'h0000; load_data = 8'h00;

    bd_load(16'hFFFC, 8'hDD);
    bd_load(16'hFFFD, 8'hCC);
    bd_load(16'hCCDD, 8'hA9);
    bd_load(16'hCCDE, 8'h19);
    bd_load(16'h0220, 8'h80);
    bd_load(16'hF010, 8'h34);
    bd_load(16'h0010, 8'h00);
    bd_load(16'h0001, 8'h00);
    bd_load(16'h0300, 8'h05);

    @(negedge clk);
    chk("rst_ready_a", rdy_a, 1'b0);
    chk("rst_ready_b", rdy_b, 1'b0);
    chk("rst_data_a", d_a, 8'h00);
`ifdef MEM_ROM_PROTECT_EN
    chk("rst_wv_a", wv_a, 1'b0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    cpu_access(0, 16'hFFFC, 1, 8'h00, 8'hDD, 0, "vec_lo");
    cpu_access(0, 16'hFFFD, 1, 8'h00, 8'hCC, 0, "vec_hi");
    cpu_access(0, 16'hCCDD, 1, 8'h00, 8'hA9, 0, "op0");
    cpu_access(0, 16'hCCDE, 1, 8'h00, 8'h19, 0, "op1");

    cpu_access(1, 16'h0220, 1, 8'h00, 8'h80, 3, "rd_wait");
    cpu_access(1, 16'h0220, 1, 8'h00, 8'h80, 0, "rd_repeat");

    cpu_access(1, 16'h0001, 0, 8'h55, 8'h00, 2, "wr_wait");
    cpu_access(1, 16'h0001, 1, 8'h00, 8'h55, 3, "wr_readback");

    cpu_access(1, 16'h3300, 1, 8'h00, 8'h05, 3, "mirror");

    cpu_access(0, 16'hF010, 0, 8'h12, 8'h34, 3, "rom_wr");
`ifdef MEM_ROM_PROTECT_EN
    cpu_access(0, 16'hF010, 1, 8'h00, 8'h34, 0, "rom_keep");
    chk("rom_wv_set", wv_a, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rom_wv_sticky", wv_a, 1'b1);
`else
    cpu_access(0, 16'hF010, 1, 8'h00, 8'h12, 0, "rom_open");
`endif

    {addr_hi, addr_lo} = 16'h0010; rnw = 1'b0; wdata = 8'hAA; data_en = 1'b1;
    @(negedge clk);
    chk("abort_stall1", rdy_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready_a", rdy_a, 1'b0);
    chk("abort_rst_ready_b", rdy_b, 1'b0);
    @(posedge clk); #1;
    rnw = 1'b1; data_en = 1'b0;
    @(negedge clk);
    chk("abort_rst_data", d_a, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MEM_ROM_PROTECT_EN
    chk("rst_wv_clear", wv_a, 1'b0);
`endif
    cpu_access(0, 16'h0010, 1, 8'h00, 8'h00, 0, "abort_nocommit");

    {addr_hi, addr_lo} = 16'h0500; rnw = 1'b1; data_en = 1'b0;
    load_en = 1'b1; load_addr = 16'h0500; load_data = 8'h77;
    @(negedge clk);
    chk("load_ready_low", rdy_a, 1'b0);
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk);
    chk("load_visible", d_a, 8'h77);
    chk("load_ready_after", rdy_a, 1'b1);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
